// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and helpers for the SPI register bank
//
// Purpose : FSM state encoding, command-bit polarity and frame-length helper
//           used by spi_reg_bank.
// Ports   : none (package)
package spi_reg_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        HDR,
        DATA,
        COMMIT
    } state_t;

    // Value of the leading R/W bit that marks a write frame.
    localparam logic CMD_WRITE = 1'b1;

    // R/W bit + address field + data field.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// rtl/spi_reg_bank_if.sv - SPI pin bundle between controller and register bank
//
// Purpose : groups the four SPI wires plus the CIPO drive enable.
// Signals : nCS, SCLK, COPI (controller -> peripheral)
//           CIPO, cipo_oe    (peripheral -> controller / pad)
// Modports: master (SPI controller side), slave (spi_reg_bank side)
interface spi_reg_bank_if;

    logic nCS;
    logic SCLK;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (
        output nCS,
        output SCLK,
        output COPI,
        input  CIPO,
        input  cipo_oe
    );

    modport slave (
        input  nCS,
        input  SCLK,
        input  COPI,
        output CIPO,
        output cipo_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser with edge-detect flop
//
// Purpose : brings one asynchronous SPI pin into the clk domain and flags
//           its edges.
// Ports   : clk, rst (sync, active-high)
//           din   - asynchronous input
//           level - synchronised level
//           rise  - one-cycle pulse on a synchronised 0->1
//           fall  - one-cycle pulse on a synchronised 1->0
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral with a read/write register bank
//
// Purpose : frames are {R/W, address, data}, MSB first. Writes commit to the
//           addressed register after nCS rises; reads shift the register out
//           on CIPO. Short frames and out-of-range writes are dropped and
//           flagged on frame_err.
// Ports   : clk, rst       - system clock, synchronous active-high reset
//           spi (slave)    - nCS, SCLK, COPI in; CIPO, cipo_oe out
//           reg_flat       - register k at [k*DATA_W +: DATA_W]
//           wr_strobe      - one-cycle pulse per register on update
//           frame_err      - one-cycle pulse per discarded frame
// Options : SPI_ERR_CNT_EN - 8-bit saturating error counter readable (and
//           cleared) at address NUM_REGS.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_HDR_LAST = CNT_W'(HDR_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_A   = (ADDR_W + 1)'(NUM_REGS);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic copi_lvl, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(spi.nCS),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(spi.SCLK),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(spi.COPI),
        .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t              state, state_nx;
    logic [1:0]          settle_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SH_W-1:0]     shreg;
    logic                rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   oshift;
    logic                cipo_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W:0]     hdr_word;
    logic [ADDR_W-1:0]   hdr_addr;
    logic                hdr_rd;
    logic                hdr_last;
    logic                addr_ok;
    logic [DATA_W-1:0]   rd_val;
    logic                cipo_oe_c, commit_wr, commit_err;

`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    // The header word as it stands once the bit arriving now is included.
    assign hdr_word = {shreg[ADDR_W-1:0], copi_lvl};
    assign hdr_addr = hdr_word[ADDR_W-1:0];
    assign hdr_rd   = (hdr_word[ADDR_W] != CMD_WRITE);
    assign hdr_last = sclk_rise && !ncs_rise && (bit_cnt == CNT_HDR_LAST);
    assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_A);

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_HIGH;
        else     state <= state_nx;
    end

    // The nCS chain resets to idle-high, so its level only reflects the pin
    // after settle_q has counted through the synchroniser depth.
    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_HIGH: if (settle_q == 2'd3 && ncs_lvl) state_nx = IDLE;
            IDLE:      if (ncs_fall) state_nx = HDR;
            HDR:       if (ncs_rise) state_nx = COMMIT;
                       else if (hdr_last) state_nx = DATA;
            DATA:      if (ncs_rise) state_nx = COMMIT;
            COMMIT:    state_nx = IDLE;
            default:   state_nx = WAIT_HIGH;
        endcase
    end

    always_comb begin
        cipo_oe_c  = 1'b0;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        if (state == DATA) cipo_oe_c = rd_q;
        if (state == COMMIT) begin
            if (bit_cnt != CNT_FULL) commit_err = 1'b1;
            else if (!rd_q) begin
                commit_wr  = addr_ok;
                commit_err = !addr_ok;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr == ADDR_W'(k)) rd_val = regs[k];
        end
`ifdef SPI_ERR_CNT_EN
        if ({1'b0, hdr_addr} == NUM_REGS_A) rd_val = DATA_W'(err_cnt);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            oshift   <= '0;
            cipo_q   <= 1'b0;
        end else begin
            if (state == WAIT_HIGH && settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            if (state == IDLE && ncs_fall) begin
                bit_cnt <= '0;
                shreg   <= '0;
                rd_q    <= 1'b0;
                cipo_q  <= 1'b0;
            end
            // Bits past a full frame are ignored; nCS rising wins over SCLK.
            if ((state == HDR || state == DATA) && sclk_rise && !ncs_rise
                    && bit_cnt != CNT_FULL) begin
                shreg   <= {shreg[SH_W-2:0], copi_lvl};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state == HDR && hdr_last) begin
                rd_q   <= hdr_rd;
                addr_q <= hdr_addr;
                oshift <= hdr_rd ? rd_val : '0;
            end
            if (cipo_oe_c && sclk_fall && !ncs_rise) begin
                cipo_q <= oshift[DATA_W-1];
                oshift <= {oshift[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= commit_err;
            for (int k = 0; k < NUM_REGS; k++) begin
                wr_strobe[k] <= 1'b0;
                if (commit_wr && addr_q == ADDR_W'(k)) begin
                    regs[k]      <= shreg[DATA_W-1:0];
                    wr_strobe[k] <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (commit_err) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (state == COMMIT && bit_cnt == CNT_FULL && rd_q
                     && {1'b0, addr_q} == NUM_REGS_A) begin
            err_cnt <= '0;
        end
    end
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign reg_flat[k*DATA_W +: DATA_W] = regs[k];
    end

    assign spi.cipo_oe = cipo_oe_c;
    assign spi.CIPO    = cipo_oe_c & cipo_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

    localparam int NR = 5;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int FW = 16;
    localparam int HW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*DW-1:0]  reg_flat;
    logic [NR-1:0]     wr_strobe;
    logic              frame_err;

    spi_reg_bank_if spi_bus();

    spi_reg_bank #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi_bus),
        .reg_flat(reg_flat), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: register contents, error count and timed commit events.
    typedef struct {
        int         cyc;
        int         kind;   // 0 write, 1 error, 2 counter clear
        int         addr;
        logic [7:0] data;
    } ev_t;

    logic [7:0] mregs [NR];
    int         mcnt;
    ev_t        evq[$];
    bit         chk_en = 1'b0;
    int         strobe_cycles = 0;
    int         err_cycles = 0;

    function automatic logic [7:0] model_rd(input int a);
        if (a < NR) return mregs[a];
`ifdef SPI_ERR_CNT_EN
        if (a == NR) return 8'(mcnt);
`endif
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) mregs[k] = 8'h00;
        mcnt = 0;
        evq.delete();
    endtask

    always @(negedge clk) begin
        logic [NR-1:0]    es;
        logic             ee;
        logic [NR*DW-1:0] ef;
        ev_t              e;
        if (chk_en) begin
            es = '0;
            ee = 1'b0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                case (e.kind)
                    0: begin mregs[e.addr] = e.data; es[e.addr] = 1'b1; end
                    1: begin ee = 1'b1; if (mcnt < 255) mcnt++; end
                    default: mcnt = 0;
                endcase
            end
            for (int k = 0; k < NR; k++) ef[k*DW +: DW] = mregs[k];
            check("reg_flat", reg_flat, ef);
            check("wr_strobe", wr_strobe, es);
            check("frame_err", frame_err, ee);
            if (!spi_bus.cipo_oe) check("cipo_idle", spi_bus.CIPO, 1'b0);
            if (wr_strobe != '0) strobe_cycles++;
            if (frame_err) err_cycles++;
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    // Sends the n low bits of 'bits' MSB first; pulses reset before bit rst_at.
    task automatic spi_frame(input logic [31:0] bits, input int n, input int rst_at,
                             output logic [7:0] got);
        logic [15:0] f;
        logic        rd;
        int          a;
        logic [7:0]  exp_rd;
        got    = 8'h00;
        f      = (n >= FW) ? 16'(bits >> (n - FW)) : 16'(bits << (FW - n));
        rd     = (f[15] == 1'b0);
        a      = int'(f[14:8]);
        exp_rd = model_rd(a);
        spi_bus.nCS = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) do_reset();
            spi_bus.COPI = bits[n-1-i];
            repeat (4) tick();
            if (i < HW) begin
                check("oe_hdr", spi_bus.cipo_oe, 1'b0);
            end else if (i < FW) begin
                check("oe_data", spi_bus.cipo_oe, rd);
                if (rd) begin
                    got[FW-1-i] = spi_bus.CIPO;
                    check("cipo_bit", spi_bus.CIPO, exp_rd[FW-1-i]);
                end
            end
            spi_bus.SCLK = 1'b1;
            repeat (4) tick();
            spi_bus.SCLK = 1'b0;
        end
        repeat (4) tick();
        spi_bus.nCS = 1'b1;
        if (rst_at < 0) begin
            if (n < FW)              evq.push_back('{cyc + 4, 1, 0, 8'h00});
            else if (!rd && a < NR)  evq.push_back('{cyc + 4, 0, a, f[7:0]});
            else if (!rd)            evq.push_back('{cyc + 4, 1, 0, 8'h00});
            else if (a == NR)        evq.push_back('{cyc + 4, 2, 0, 8'h00});
        end
        spi_bus.COPI = 1'b0;
        repeat (10) tick();
        check("oe_after", spi_bus.cipo_oe, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0]       got;
        int               s0, e0;
        logic [NR*DW-1:0] snap;

        spi_bus.nCS  = 1'b1;
        spi_bus.SCLK = 1'b0;
        spi_bus.COPI = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        check("rst_reg_flat", reg_flat, 40'h0);
        check("rst_wr_strobe", wr_strobe, 5'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_cipo_oe", spi_bus.cipo_oe, 1'b0);
        check("rst_cipo", spi_bus.CIPO, 1'b0);
        chk_en = 1'b1;
        repeat (8) tick();

        // Write addr 4 = 0xA5
        s0 = strobe_cycles;
        spi_frame(32'h84A5, 16, -1, got);
        check("t1_reg4", reg_flat[39:32], 8'hA5);
        check("t1_others", reg_flat[31:0], 32'h0);
        check("t1_strobe_cycles", strobe_cycles - s0, 1);

        // Write addr 2 = 0x3C, read it back
        spi_frame(32'h823C, 16, -1, got);
        s0 = strobe_cycles;
        spi_frame(32'h0200, 16, -1, got);
        check("t2_read_data", got, 8'h3C);
        check("t2_no_strobe", strobe_cycles - s0, 0);

        // 10-bit short frame to addr 1
        e0 = err_cycles;
        spi_frame(32'h204, 10, -1, got);
        check("t3_err_pulses", err_cycles - e0, 1);
        check("t3_reg1", reg_flat[15:8], 8'h00);

        // Out-of-range write, then 20-bit write to addr 0
        snap = reg_flat;
        e0 = err_cycles;
        spi_frame(32'h90FF, 16, -1, got);
        check("t4_err_pulses", err_cycles - e0, 1);
        check("t4_unchanged", reg_flat, snap);
        spi_frame(32'h805AF, 20, -1, got);
        check("t4_reg0", reg_flat[7:0], 8'h5A);

        // Read of an unimplemented address returns zero
        spi_frame(32'h7F00, 16, -1, got);
        check("t5_read_oor", got, 8'h00);

        // Reset in the middle of a frame: no commit, no error
        s0 = strobe_cycles;
        e0 = err_cycles;
        spi_frame(32'h8311, 16, 5, got);
        check("t6_no_strobe", strobe_cycles - s0, 0);
        check("t6_no_err", err_cycles - e0, 0);
        check("t6_regs_reset", reg_flat, 40'h0);
        spi_frame(32'h8377, 16, -1, got);
        check("t6_reg3", reg_flat[31:24], 8'h77);

        // Two bad frames, then read the error counter address twice
        spi_frame(32'h204, 10, -1, got);
        spi_frame(32'h85AA, 16, -1, got);
        spi_frame(32'h0500, 16, -1, got);
`ifdef SPI_ERR_CNT_EN
        check("t7_errcnt_first", got, 8'h02);
`else
        check("t7_errcnt_first", got, 8'h00);
`endif
        spi_frame(32'h0500, 16, -1, got);
        check("t7_errcnt_second", got, 8'h00);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI (mode 0) peripheral that gives the host write and read-back access to a bank of NUM_REGS configuration registers, each DATA_W bits wide. It generalises the fixed 5×8-bit write-only register interface that feeds the output-enable, PWM-enable and duty-cycle logic. New behaviour over that interface: CIPO read-back, per-register write strobes, and discard-with-error for short frames and out-of-range addresses. SCLK, nCS and COPI are asynchronous and are oversampled by clk.

Parameters:
NUM_REGS, 5, number of implemented registers; must be ≤ 2**ADDR_W
ADDR_W, 7, address field width in bits
DATA_W, 8, register and data field width in bits
RESET_VAL, 0, reset value of every register (DATA_W bits)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
nCS  in  1  SPI chip select, active low, asynchronous
SCLK  in  1  SPI clock, asynchronous, f(SCLK) ≤ f(clk)/8
COPI  in  1  SPI controller-out data, asynchronous
CIPO  out  1  SPI peripheral-out data
cipo_oe  out  1  CIPO drive enable
reg_flat  out  NUM_REGS*DATA_W  register contents; register k occupies bits [k*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-cycle pulse on the cycle register k updates
frame_err  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Synchronisers: nCS, SCLK and COPI each pass through 2 flops, plus a third flop for edge detection.
  - Reset values: nCS chain 1, SCLK chain 0, COPI chain 0.
  - Edges are detected on synchronised signals only.
- Frame format, MSB first: 1 R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits. FRAME_W = 1+ADDR_W+DATA_W (16 with defaults).
- COPI is sampled on SCLK rising edges. CIPO changes only on SCLK falling edges.
- Bit counter: clog2(FRAME_W+1) bits. It saturates at FRAME_W; bits after that are ignored.
- States:
  - WAIT_HIGH: entered on reset. Go to IDLE once synced nCS = 1. This prevents a frame being captured if nCS is already low when reset ends.
  - IDLE: on synced nCS falling edge, clear the counter and shift register, then go to HDR.
  - HDR: shift in the R/W and address bits. After the (1+ADDR_W)th bit, go to DATA.
    - Read with address < NUM_REGS: load the output shifter with that register.
    - Read with address ≥ NUM_REGS: load the output shifter with 0.
  - DATA: shift in the data bits. Reads shift the output out.
    - On a synced nCS rising edge in any active state, go to COMMIT.
  - COMMIT: lasts one cycle, then return to IDLE.
    - Write with counter = FRAME_W and address < NUM_REGS: register[addr] ← data, and wr_strobe[addr] = 1 in the same cycle.
    - Short frame (counter < FRAME_W), or write to address ≥ NUM_REGS: no register changes and frame_err = 1.
    - A complete read has no effect.
- Latency: a register updates 4 clk cycles after the nCS pin rises (3 synchroniser/edge cycles + COMMIT).
- CIPO and cipo_oe:
  - cipo_oe = 1 only in DATA during a read; otherwise cipo_oe = 0 and CIPO = 0.
  - The MSB is driven on the first SCLK falling edge after the last address bit.
- Reset values: reg_flat = RESET_VAL for all registers; wr_strobe = 0; frame_err = 0; CIPO = 0; cipo_oe = 0; state = WAIT_HIGH.
- Reset mid-frame: the partial frame is dropped and there is no commit.
- nCS rising and SCLK edge in the same cycle: nCS takes priority and the SCLK edge is ignored.
- A read and a commit never overlap: there is only one frame in flight.

Optional Feature:
SPI_ERR_CNT_EN:
- Defined: adds an 8-bit saturating counter (reset 0) that increments on each frame_err pulse and stops at 0xFF.
  - A read of address NUM_REGS returns the counter, zero-extended or truncated to DATA_W, and clears it in COMMIT.
  - A write to address NUM_REGS is still an error.
- Undefined: no counter; address NUM_REGS reads 0.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum (WAIT_HIGH, IDLE, HDR, DATA, COMMIT)
  - CMD_WRITE = 1'b1
  - function frame_w(addr_w, data_w)
- One sub-module, spi_sync_edge: 2-flop synchroniser plus edge flop, with outputs level, rise and fall. It is instantiated three times.

Test Plan:
- Write addr 0x04 data 0xA5 (bits 1_0000100_10100101): reg4 = 0xA5 and wr_strobe = 5'b10000 for exactly 1 cycle, 4 clk after nCS rises; other registers unchanged.
- Write addr 0x02 data 0x3C, then read addr 0x02: CIPO = 0,0,1,1,1,1,0,0 on the 8 data bits; cipo_oe high only in DATA; no wr_strobe.
- Short frame of 10 bits (write addr 0x01): frame_err pulses once; reg1 stays 0x00.
- Write addr 0x10 data 0xFF: frame_err pulses; reg_flat unchanged. Then a 20-bit write to addr 0x00 data 0x5A: reg0 = 0x5A (extra bits ignored).
- Assert rst for 2 clk mid-frame with nCS held low, release, finish clocking bits, raise nCS: no commit and no frame_err. The next full frame commits normally.
- SPI_ERR_CNT_EN: two bad frames, then read addr 0x05 returns 0x02; a second read returns 0x00.
